// File: rtl/uart_csr_bank_pkg.sv
// Shared register-map offsets, bit-field indices and control-word layout for
// the UART CSR bank.
package uart_csr_bank_pkg;

  localparam int OFF_DATA     = 'h00;
  localparam int OFF_CTRL     = 'h04;
  localparam int OFF_BAUD     = 'h08;
  localparam int OFF_STATUS   = 'h0C;
  localparam int OFF_INT_EN   = 'h10;
  localparam int OFF_INT_STAT = 'h14;

  localparam int CTRL_UART_EN    = 0;
  localparam int CTRL_STOP2      = 1;
  localparam int CTRL_PARITY_ODD = 2;
  localparam int CTRL_PARITY_EN  = 3;
  localparam int CTRL_TX_EN      = 4;
  localparam int CTRL_RX_EN      = 5;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_RX_EMPTY = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_IRQ      = 4;
  localparam int STAT_W        = 5;

  localparam int INT_PARITY_ERR  = 0;
  localparam int INT_STOP_ERR    = 1;
  localparam int INT_RX_UNDERRUN = 2;
  localparam int INT_TX_OVERFLOW = 3;
  localparam int INT_RX_AVAIL    = 4;
  localparam int INT_TX_READY    = 5;
  localparam int INT_STAT_W      = 4;
  localparam int INT_EN_W        = 6;

  // Field order mirrors the CTRL register, so bit 0 is uart_en.
  typedef struct packed {
    logic rx_en;
    logic tx_en;
    logic parity_en;
    logic parity_odd;
    logic stop2;
    logic uart_en;
  } uart_ctrl_t;

endpackage

// File: rtl/uart_csr_bank_w1c.sv
// Sticky status bits: set by an event pulse, cleared by writing 1; set wins
// when both arrive in the same cycle.
module uart_w1c_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          q_reg[gi] <= 1'b0;
        end else if (set[gi]) begin
          q_reg[gi] <= 1'b1;
        end else if (clr[gi]) begin
          q_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign q = q_reg;

endmodule

// File: rtl/uart_csr_bank.sv
// Register bank between a simple strobe bus and a UART core: control, baud,
// data FIFO access, status, and masked interrupt generation.
module uart_csr_bank
  import uart_csr_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              uart_sel,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  input  logic              tx_full,
  input  logic              rx_full,
  input  logic              rx_empty,
  input  logic              busy,
  input  logic              parity_err,
  input  logic              stop_err,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_pop,
  output logic              tx_push,
  output logic [DATA_W-1:0] tx_data,
  output logic              uart_en,
  output logic              tx_en,
  output logic              rx_en,
  output logic              parity_en,
  output logic              parity_odd,
  output logic              stop2,
  output logic [BAUD_W-1:0] baud_div,
  output logic              irq
);

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  sel_data;
  logic                  sel_ctrl;
  logic                  sel_baud;
  logic                  sel_status;
  logic                  sel_int_en;
  logic                  sel_int_stat;
  uart_ctrl_t            ctrl_reg;
  uart_ctrl_t            ctrl_next;
  logic [BAUD_W-1:0]     baud_reg;
  logic [INT_EN_W-1:0]   int_en_reg;
  logic [INT_STAT_W-1:0] int_stat;
  logic [INT_STAT_W-1:0] int_set;
  logic [INT_STAT_W-1:0] int_clr;
  logic [DATA_W-1:0]     tx_data_reg;
  logic                  tx_push_reg;
  logic                  rvalid_reg;
  logic                  irq_reg;
  logic                  irq_next;
  logic [31:0]           rdata_reg;
  logic [31:0]           rdata_next;
  logic [STAT_W-1:0]     status_word;
  logic                  unused_wdata;

  // A simultaneous read and write is treated as a write only.
  assign wr_acc = uart_sel & wr_en;
  assign rd_acc = uart_sel & rd_en & ~wr_en;

  assign sel_data     = (addr == ADDR_W'(OFF_DATA));
  assign sel_ctrl     = (addr == ADDR_W'(OFF_CTRL));
  assign sel_baud     = (addr == ADDR_W'(OFF_BAUD));
  assign sel_status   = (addr == ADDR_W'(OFF_STATUS));
  assign sel_int_en   = (addr == ADDR_W'(OFF_INT_EN));
  assign sel_int_stat = (addr == ADDR_W'(OFF_INT_STAT));

  assign rx_pop = rd_acc & sel_data & ~rx_empty;

  always_comb begin
    ctrl_next            = ctrl_reg;
    ctrl_next.uart_en    = wdata[CTRL_UART_EN];
    ctrl_next.stop2      = wdata[CTRL_STOP2];
    ctrl_next.parity_odd = wdata[CTRL_PARITY_ODD];
    ctrl_next.parity_en  = wdata[CTRL_PARITY_EN];
    ctrl_next.tx_en      = wdata[CTRL_TX_EN];
    ctrl_next.rx_en      = wdata[CTRL_RX_EN];
  end

  always_comb begin
    int_set                  = '0;
    int_set[INT_PARITY_ERR]  = parity_err;
    int_set[INT_STOP_ERR]    = stop_err;
    int_set[INT_RX_UNDERRUN] = rd_acc & sel_data & rx_empty;
    int_set[INT_TX_OVERFLOW] = wr_acc & sel_data & tx_full;
  end

  assign int_clr = (wr_acc & sel_int_stat) ? wdata[INT_STAT_W-1:0] : '0;

  uart_w1c_reg #(
    .WIDTH(INT_STAT_W)
  ) u_int_stat (
    .clock(clock),
    .reset(reset),
    .set  (int_set),
    .clr  (int_clr),
    .q    (int_stat)
  );

  always_comb begin
    status_word                = '0;
    status_word[STAT_BUSY]     = busy;
    status_word[STAT_RX_EMPTY] = rx_empty;
    status_word[STAT_RX_FULL]  = rx_full;
    status_word[STAT_TX_FULL]  = tx_full;
    status_word[STAT_IRQ]      = irq_reg;
  end

  always_comb begin
    rdata_next = '0;
    if (sel_data) begin
      rdata_next = rx_empty ? '0 : 32'(rx_data);
    end else if (sel_ctrl) begin
      rdata_next = 32'(ctrl_reg);
    end else if (sel_baud) begin
      rdata_next = 32'(baud_reg);
    end else if (sel_status) begin
      rdata_next = 32'(status_word);
    end else if (sel_int_en) begin
      rdata_next = 32'(int_en_reg);
    end else if (sel_int_stat) begin
      rdata_next = 32'(int_stat);
    end
  end

  assign irq_next = (|(int_stat & int_en_reg[INT_STAT_W-1:0]))
                  | (int_en_reg[INT_RX_AVAIL] & ~rx_empty)
                  | (int_en_reg[INT_TX_READY] & ~tx_full);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_reg    <= '0;
      baud_reg    <= '0;
      int_en_reg  <= '0;
      tx_data_reg <= '0;
      tx_push_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      irq_reg     <= 1'b0;
    end else begin
      tx_push_reg <= 1'b0;
      rvalid_reg  <= rd_acc;
      irq_reg     <= irq_next;
      if (rd_acc) begin
        rdata_reg <= rdata_next;
      end
      if (wr_acc) begin
        if (sel_data && !tx_full) begin
          tx_data_reg <= wdata[DATA_W-1:0];
          tx_push_reg <= 1'b1;
        end
        if (sel_ctrl && !busy) begin
          ctrl_reg <= ctrl_next;
        end
        // Divisor is frozen while the core runs or is enabled.
        if (sel_baud && !busy && !ctrl_reg.uart_en) begin
          baud_reg <= wdata[BAUD_W-1:0];
        end
        if (sel_int_en) begin
          int_en_reg <= wdata[INT_EN_W-1:0];
        end
      end
    end
  end

  assign rdata      = rdata_reg;
  assign rvalid     = rvalid_reg;
  assign tx_push    = tx_push_reg;
  assign tx_data    = tx_data_reg;
  assign baud_div   = baud_reg;
  assign irq        = irq_reg;
  assign uart_en    = ctrl_reg.uart_en;
  assign tx_en      = ctrl_reg.tx_en;
  assign rx_en      = ctrl_reg.rx_en;
  assign parity_en  = ctrl_reg.parity_en;
  assign parity_odd = ctrl_reg.parity_odd;
  assign stop2      = ctrl_reg.stop2;

  assign unused_wdata = ^wdata;

endmodule

// File: tb/tb_uart_csr_bank.sv
// Bench for uart_csr_bank: directed scenarios plus randomized traffic, all
// outputs compared each cycle against a register-map level model.
module tb_uart_csr_bank;

  localparam int DATA_W = 8;
  localparam int BAUD_W = 16;
  localparam int ADDR_W = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              uart_sel = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              tx_full = 1'b0;
  logic              rx_full = 1'b0;
  logic              rx_empty = 1'b1;
  logic              busy = 1'b0;
  logic              parity_err = 1'b0;
  logic              stop_err = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_pop;
  logic              tx_push;
  logic [DATA_W-1:0] tx_data;
  logic              uart_en;
  logic              tx_en;
  logic              rx_en;
  logic              parity_en;
  logic              parity_odd;
  logic              stop2;
  logic [BAUD_W-1:0] baud_div;
  logic              irq;

  always #5 clock = ~clock;

  uart_csr_bank #(
    .DATA_W(DATA_W),
    .BAUD_W(BAUD_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .uart_sel  (uart_sel),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .tx_full   (tx_full),
    .rx_full   (rx_full),
    .rx_empty  (rx_empty),
    .busy      (busy),
    .parity_err(parity_err),
    .stop_err  (stop_err),
    .rx_data   (rx_data),
    .rx_pop    (rx_pop),
    .tx_push   (tx_push),
    .tx_data   (tx_data),
    .uart_en   (uart_en),
    .tx_en     (tx_en),
    .rx_en     (rx_en),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .stop2     (stop2),
    .baud_div  (baud_div),
    .irq       (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: the programmer-visible registers plus the registered outputs.
  typedef struct packed {
    logic [5:0]        ctrl;
    logic [BAUD_W-1:0] baud;
    logic [5:0]        int_en;
    logic [3:0]        stat;
    logic [DATA_W-1:0] tx_data;
    logic              tx_push;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              irq;
  } model_t;

  model_t m = '0;

  function automatic logic [31:0] reg_view(model_t s, int off);
    case (off)
      'h00:    return rx_empty ? 32'd0 : 32'(rx_data);
      'h04:    return 32'(s.ctrl);
      'h08:    return 32'(s.baud);
      'h0C:    return {27'd0, s.irq, tx_full, rx_full, rx_empty, busy};
      'h10:    return 32'(s.int_en);
      'h14:    return 32'(s.stat);
      default: return 32'd0;
    endcase
  endfunction

  function automatic model_t model_next(model_t s);
    model_t     n   = s;
    int         off = int'(addr);
    bit         w   = uart_sel && wr_en;
    bit         r   = uart_sel && rd_en && !wr_en;
    logic [3:0] ev  = {2'b00, stop_err, parity_err};
    n.tx_push = 1'b0;
    n.rvalid  = r;
    n.irq     = ((s.stat & s.int_en[3:0]) != 4'd0) || (s.int_en[4] && !rx_empty)
             || (s.int_en[5] && !tx_full);
    if (r) begin
      n.rdata = reg_view(s, off);
      if (off == 0 && rx_empty) ev[2] = 1'b1;
    end
    if (w) begin
      case (off)
        'h00: begin
          if (tx_full) ev[3] = 1'b1;
          else begin
            n.tx_data = wdata[DATA_W-1:0];
            n.tx_push = 1'b1;
          end
        end
        'h04: if (!busy) n.ctrl = wdata[5:0];
        'h08: if (!busy && !s.ctrl[0]) n.baud = wdata[BAUD_W-1:0];
        'h10: n.int_en = wdata[5:0];
        'h14: n.stat = s.stat & ~wdata[3:0];
        default: ;
      endcase
    end
    n.stat = n.stat | ev;
    return n;
  endfunction

  function automatic logic exp_pop();
    return uart_sel && rd_en && !wr_en && (addr == 5'd0) && !rx_empty;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) m <= '0;
    else        m <= model_next(m);
  end

  always @(negedge clock) begin
    chk("rdata", rdata, m.rdata);
    chk("rvalid", 32'(rvalid), 32'(m.rvalid));
    chk("tx_push", 32'(tx_push), 32'(m.tx_push));
    chk("tx_data", 32'(tx_data), 32'(m.tx_data));
    chk("ctrl", 32'({rx_en, tx_en, parity_en, parity_odd, stop2, uart_en}), 32'(m.ctrl));
    chk("baud_div", 32'(baud_div), 32'(m.baud));
    chk("irq", 32'(irq), 32'(m.irq));
    chk("rx_pop", 32'(rx_pop), 32'(exp_pop()));
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    uart_sel = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    uart_sel = 1'b1;
    wr_en    = 1'b1;
    rd_en    = 1'b0;
    addr     = ADDR_W'(a);
    wdata    = d;
    step();
    idle();
  endtask

  task automatic do_read(input int a);
    uart_sel = 1'b1;
    rd_en    = 1'b1;
    wr_en    = 1'b0;
    addr     = ADDR_W'(a);
    step();
    idle();
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #2;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_baud", 32'(baud_div), 32'd0);
    chk("rst_tx_push", 32'(tx_push), 32'd0);
    reset = 1'b1;
    step();

    // Baud programming and read-back latency
    do_write('h08, 32'h0000_01B2);
    do_read('h08);
    chk("baud_rd", rdata, 32'h0000_01B2);
    chk("baud_rvalid", 32'(rvalid), 32'd1);
    step();
    chk("rvalid_pulse", 32'(rvalid), 32'd0);

    // Baud locked once enabled
    do_write('h04, 32'h1);
    chk("uart_en_set", 32'(uart_en), 32'd1);
    do_write('h08, 32'h10);
    do_read('h08);
    chk("baud_locked", rdata, 32'h0000_01B2);
    chk("baud_div_locked", 32'(baud_div), 32'h1B2);

    // TX push and overflow
    tx_full = 1'b0;
    do_write('h00, 32'h5A);
    chk("tx_push_hi", 32'(tx_push), 32'd1);
    chk("tx_data_5a", 32'(tx_data), 32'h5A);
    step();
    chk("tx_push_lo", 32'(tx_push), 32'd0);
    tx_full = 1'b1;
    do_write('h00, 32'hA5);
    chk("ovf_no_push", 32'(tx_push), 32'd0);
    chk("ovf_tx_data", 32'(tx_data), 32'h5A);
    do_read('h14);
    chk("int_stat_ovf", rdata, 32'h8);
    tx_full = 1'b0;
    do_write('h14, 32'hF);

    // RX underrun and pop
    rx_empty = 1'b1;
    uart_sel = 1'b1; rd_en = 1'b1; addr = 5'd0;
    #1 chk("udr_no_pop", 32'(rx_pop), 32'd0);
    step(); idle();
    chk("udr_rdata", rdata, 32'd0);
    do_read('h14);
    chk("int_stat_udr", rdata, 32'h4);
    rx_empty = 1'b0; rx_data = 8'h3C;
    uart_sel = 1'b1; rd_en = 1'b1; addr = 5'd0;
    #1 chk("pop_hi", 32'(rx_pop), 32'd1);
    step(); idle();
    chk("pop_rdata", rdata, 32'h3C);
    #1 chk("pop_lo", 32'(rx_pop), 32'd0);
    rx_empty = 1'b1;

    // STATUS live view, unmapped offset, read+write collision
    busy = 1'b1;
    do_read('h0C);
    chk("status", rdata, 32'h3);
    busy = 1'b0;
    do_read('h18);
    chk("unmapped", rdata, 32'd0);
    uart_sel = 1'b1; rd_en = 1'b1; wr_en = 1'b1; addr = 5'h10; wdata = 32'h0;
    step(); idle();
    chk("collide_no_rvalid", 32'(rvalid), 32'd0);

    // Interrupt path and set-over-clear priority
    do_write('h14, 32'hF);
    do_write('h10, 32'h01);
    parity_err = 1'b1;
    step();
    parity_err = 1'b0;
    chk("irq_lag", 32'(irq), 32'd0);
    step();
    chk("irq_par", 32'(irq), 32'd1);
    parity_err = 1'b1;
    do_write('h14, 32'h1);
    parity_err = 1'b0;
    do_read('h14);
    chk("set_wins", rdata, 32'h1);
    chk("irq_held", 32'(irq), 32'd1);
    do_write('h14, 32'h1);
    chk("irq_before_drop", 32'(irq), 32'd1);
    step();
    chk("irq_cleared", 32'(irq), 32'd0);

    // Reset during a DATA write
    uart_sel = 1'b1; wr_en = 1'b1; addr = 5'd0; wdata = 32'h77;
    #1 reset = 1'b0;
    step(); idle();
    chk("rst_mid_push", 32'(tx_push), 32'd0);
    chk("rst_mid_tx_data", 32'(tx_data), 32'd0);
    chk("rst_mid_baud", 32'(baud_div), 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    chk("rst_mid_uart_en", 32'(uart_en), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_push", 32'(tx_push), 32'd0);
    step();
    chk("post_rst_push2", 32'(tx_push), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      uart_sel   = ($urandom_range(0, 9) < 8);
      wr_en      = ($urandom_range(0, 9) < 4);
      rd_en      = ($urandom_range(0, 9) < 4);
      addr       = ($urandom_range(0, 3) != 0) ? ADDR_W'($urandom_range(0, 5) * 4)
                                              : ADDR_W'($urandom_range(0, 31));
      wdata      = $urandom();
      busy       = ($urandom_range(0, 4) == 0);
      tx_full    = ($urandom_range(0, 9) < 3);
      rx_empty   = ($urandom_range(0, 9) < 4);
      rx_full    = ($urandom_range(0, 9) < 2);
      parity_err = ($urandom_range(0, 19) == 0);
      stop_err   = ($urandom_range(0, 19) == 0);
      rx_data    = DATA_W'($urandom());
      step();
    end
    idle();
    parity_err = 1'b0;
    stop_err   = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
